mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter TMO, default 15: maximum cycles to wait for mem_ready before abort, range 1..255.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  fetch request, held high until if_ack.
REQ-007 if_addr  in  ADDR_W  fetch address, stable while if_req is high.
REQ-008 if_rdata  out  DATA_W  fetched word, valid while if_ack is high.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 ls_req  in  1  load/store request, held high until ls_ack.
REQ-011 ls_we  in  1  1 = store, 0 = load.
REQ-012 ls_addr  in  ADDR_W  load/store address.
REQ-013 ls_wdata  in  DATA_W  store data.
REQ-014 ls_be  in  DATA_W/8  store byte enables.
REQ-015 ls_rdata  out  DATA_W  load data, valid while ls_ack is high.
REQ-016 ls_ack  out  1  one-cycle load/store completion pulse.
REQ-017 err  out  1  one-cycle pulse with the ack of a timed-out transfer.
REQ-018 mem_en, mem_we, mem_addr, mem_wdata, mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  single-port memory command, registered.
REQ-019 mem_rdata  in  DATA_W  read data, valid in the mem_ready cycle.
REQ-020 mem_ready  in  1  memory completion, ignored while mem_en is low.

Function
REQ-021 FSM states SHALL be IDLE, BUSY, RESP.
REQ-022 IDLE: no request -> stay. Any request -> latch the winner's command into the mem_* registers, set mem_en=1, clear the wait counter, go to BUSY.
REQ-023 Arbitration SHALL be round-robin. A sole requester wins. On a tie, the winner is the requester not granted last. last_grant resets to LS, so the first tie goes to IF.
REQ-024 BUSY: mem_* outputs SHALL stay constant. mem_ready=1 -> capture mem_rdata into the winner's rdata register, drop mem_en, go to RESP.
REQ-025 BUSY: the wait counter SHALL increment each cycle without mem_ready. If it reaches TMO, drop mem_en, force the winner's rdata to 0, set the err flag, go to RESP.
REQ-026 RESP: the winner's ack (and err, if set) SHALL be high for exactly one cycle. Update last_grant, then go to IDLE.
REQ-027 Latency: request first high at edge t -> mem_en high after t -> ack high after edge t+1+k, where k ≥ 1 is the number of BUSY cycles. Minimum request-to-ack is 3 cycles.
REQ-028 Back-to-back: at least one IDLE cycle SHALL separate consecutive transfers, so a request held through its ack is never double-granted.
REQ-029 A request that arrives while BUSY/RESP SHALL wait and be arbitrated in the next IDLE cycle.
REQ-030 The loser's ack and rdata SHALL stay 0 and unchanged.
REQ-031 if_ack and ls_ack SHALL never be high in the same cycle.
REQ-032 mem_we SHALL be 0 for every IF grant, and mem_be SHALL be all-ones for IF grants and for loads.
REQ-033 mem_ready while not BUSY SHALL be ignored.

Reset
REQ-034 rst high SHALL immediately force state=IDLE, mem_en=mem_we=0, mem_addr/mem_wdata/mem_be=0, if_ack=ls_ack=err=0, if_rdata=ls_rdata=0, counter=0, last_grant=LS.
REQ-035 A reset during BUSY SHALL abandon the transfer with no ack. A requester still high after reset release SHALL be re-arbitrated.

Structure
REQ-036 Package rvs_pkg SHALL hold typedef arb_state_t {IDLE, BUSY, RESP} and typedef grant_t {G_IF, G_LS}.
REQ-037 The wait counter SHALL be sub-module mem_wait_timer (clear, enable, TMO parameter, expired output).
REQ-038 No combinational path SHALL exist from mem_ready to any output.

Verification
REQ-039 Single fetch: if_req=1, if_addr=0x10, mem_ready=1 in the 1st BUSY cycle, mem_rdata=0x00500093 -> mem_en high one cycle, if_ack one cycle later, if_rdata=0x00500093, 3 cycles total.
REQ-040 Simultaneous requests after reset: if_req=ls_req=1 -> IF granted first, LS next after one IDLE cycle. Repeat the tie -> LS granted first.
REQ-041 Store: ls_we=1, ls_addr=0x200, ls_wdata=0xDEADBEEF, ls_be=0x3, mem_ready after 4 cycles -> mem_* stable 4 cycles, mem_we=1, ls_ack pulse, if_ack=0.
REQ-042 Timeout: TMO=15, ls_req load, mem_ready never -> mem_en drops after 15 BUSY cycles, ls_ack=err=1 for one cycle, ls_rdata=0.
REQ-043 Reset mid-BUSY: assert rst in the 2nd BUSY cycle -> all outputs 0 in the same cycle, no ack. if_req still high after release -> fresh transfer completes.
REQ-044 Stray mem_ready=1 in IDLE with no requests -> no ack, no state change.

Source files
------------

// File: rtl/rvs_pkg.sv
// Shared types for the instruction-fetch / load-store memory arbiter.
package rvs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    G_IF,
    G_LS
  } grant_t;

  localparam int WAIT_CNT_W = 8;

endpackage : rvs_pkg

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles spent waiting for mem_ready; expired flags the cycle
// whose increment reaches TMO, so the transfer aborts after exactly TMO waits.
module mem_wait_timer
  import rvs_pkg::*;
#(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] count_q;
  logic [WAIT_CNT_W-1:0] count_d;

  // NOTE: next-state logic gets a default assignment first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == WAIT_CNT_W'(TMO - 1));

endmodule : mem_wait_timer

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction
// fetch port and a load/store port; every output is registered.
module mem_arbiter
  import rvs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_ack,
  output logic                err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  arb_state_t          state_q;
  grant_t              grant_q, last_grant_q, win_d;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_be_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;
  logic                if_ack_q, ls_ack_q, err_q;
  logic                timer_clear, timer_en, timer_expired;

  // A tie goes to whichever port was not served last.
  always_comb begin
    win_d = G_IF;
    if (if_req && ls_req) begin
      win_d = (last_grant_q == G_LS) ? G_IF : G_LS;
    end else if (ls_req) begin
      win_d = G_LS;
    end
  end

  assign timer_clear = (state_q == IDLE);
  assign timer_en    = (state_q == BUSY) && !mem_ready;

  mem_wait_timer #(.TMO(TMO)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= G_IF;
      last_grant_q <= G_LS;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      if_ack_q     <= 1'b0;
      ls_ack_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_req || ls_req) begin
            grant_q  <= win_d;
            mem_en_q <= 1'b1;
            if (win_d == G_IF) begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end else begin
              mem_we_q    <= ls_we;
              mem_addr_q  <= ls_addr;
              mem_wdata_q <= ls_we ? ls_wdata : '0;
              mem_be_q    <= ls_we ? ls_be : '1;
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // A completing mem_ready wins over a simultaneous timeout.
          if (mem_ready || timer_expired) begin
            mem_en_q <= 1'b0;
            err_q    <= !mem_ready;
            if (grant_q == G_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              ls_ack_q   <= 1'b1;
              ls_rdata_q <= mem_ready ? mem_rdata : '0;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if_ack_q     <= 1'b0;
          ls_ack_q     <= 1'b0;
          err_q        <= 1'b0;
          if_rdata_q   <= '0;
          ls_rdata_q   <= '0;
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign err       = err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model is compared every
// cycle, and literal expectations pin the key scenarios.
module tb_mem_arbiter;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        if_req, ls_req, ls_we, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        if_ack, ls_ack, err, mem_en, mem_we;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_be     (ls_be),
    .ls_rdata  (ls_rdata),
    .ls_ack    (ls_ack),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what a port should see given the request
  // and memory-handshake history.
  typedef struct packed {
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        if_ack;
    logic        ls_ack;
    logic        err;
    logic [31:0] if_rdata;
    logic [31:0] ls_rdata;
  } exp_t;

  exp_t e       = '0;
  int   age     = -1;
  bit   cur_ls  = 1'b0;
  bit   last_ls = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e       = '0;
      age     = -1;
      cur_ls  = 1'b0;
      last_ls = 1'b1;
    end else if (e.if_ack || e.ls_ack) begin
      last_ls    = cur_ls;
      e.if_ack   = 1'b0;
      e.ls_ack   = 1'b0;
      e.err      = 1'b0;
      e.if_rdata = '0;
      e.ls_rdata = '0;
      age        = -1;
    end else if (e.en) begin
      age++;
      if (mem_ready || age == TMO) begin
        e.en  = 1'b0;
        e.err = !mem_ready;
        if (cur_ls) begin
          e.ls_ack   = 1'b1;
          e.ls_rdata = mem_ready ? mem_rdata : 32'h0;
        end else begin
          e.if_ack   = 1'b1;
          e.if_rdata = mem_ready ? mem_rdata : 32'h0;
        end
      end
    end else if (if_req || ls_req) begin
      cur_ls = ls_req && (!if_req || !last_ls);
      e.en   = 1'b1;
      age    = 0;
      if (cur_ls) begin
        e.we    = ls_we;
        e.addr  = ls_addr;
        e.wdata = ls_we ? ls_wdata : 32'h0;
        e.be    = ls_we ? ls_be : 4'hF;
      end else begin
        e.we    = 1'b0;
        e.addr  = if_addr;
        e.wdata = 32'h0;
        e.be    = 4'hF;
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    check("cmp_mem_en",    mem_en,    e.en);
    check("cmp_mem_we",    mem_we,    e.we);
    check("cmp_mem_addr",  mem_addr,  e.addr);
    check("cmp_mem_wdata", mem_wdata, e.wdata);
    check("cmp_mem_be",    mem_be,    e.be);
    check("cmp_if_ack",    if_ack,    e.if_ack);
    check("cmp_ls_ack",    ls_ack,    e.ls_ack);
    check("cmp_err",       err,       e.err);
    check("cmp_if_rdata",  if_rdata,  e.if_rdata);
    check("cmp_ls_rdata",  ls_rdata,  e.ls_rdata);
    check("cmp_ack_excl",  if_ack && ls_ack, 1'b0);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_en;
    bit  got;
    bit  exp_ls;

    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_be = '0; mem_rdata = '0;
    repeat (3) tick();
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_if_ack", if_ack, 1'b0);
    check("rst_rdata",  ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Single fetch, memory ready in the first BUSY cycle.
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    check("fetch_mem_en", mem_en,   1'b1);
    check("fetch_addr",   mem_addr, 32'h10);
    check("fetch_we",     mem_we,   1'b0);
    check("fetch_be",     mem_be,   4'hF);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    tick();
    check("fetch_ack",         if_ack,     1'b1);
    check("fetch_rdata",       if_rdata,   32'h00500093);
    check("fetch_en_drop",     mem_en,     1'b0);
    check("model_fetch_rdata", e.if_rdata, 32'h00500093);
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    check("fetch_ack_pulse", if_ack, 1'b0);

    // Both ports requesting continuously: grants alternate IF, LS, IF, LS.
    do_reset();
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
    mem_ready = 1'b1; mem_rdata = 32'hA5A50001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 3 == 2) begin
        exp_ls = ((c / 3) % 2) == 1;
        check("rr_if_ack", if_ack, !exp_ls);
        check("rr_ls_ack", ls_ack, exp_ls);
      end
      if (c == 2) check("model_rr_first", e.if_ack, 1'b1);
    end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Store held four BUSY cycles before the memory answers.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF;
    ls_be = 4'h3; mem_rdata = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("st_en",    mem_en,    1'b1);
      check("st_we",    mem_we,    1'b1);
      check("st_addr",  mem_addr,  32'h200);
      check("st_wdata", mem_wdata, 32'hDEADBEEF);
      check("st_be",    mem_be,    4'h3);
      if (c == 4) mem_ready = 1'b1;
    end
    tick();
    check("st_ls_ack",  ls_ack, 1'b1);
    check("st_if_ack",  if_ack, 1'b0);
    check("st_en_drop", mem_en, 1'b0);
    ls_req = 1'b0; ls_we = 1'b0; mem_ready = 1'b0;
    tick();

    // Load that never completes: aborts after TMO waits with err.
    ls_req = 1'b1; ls_addr = 32'h40; ls_be = 4'h0; mem_rdata = 32'hFFFFFFFF;
    n_en = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_en) n_en++;
      else break;
    end
    check("tmo_busy_cycles", n_en,     15);
    check("tmo_ls_ack",      ls_ack,   1'b1);
    check("tmo_err",         err,      1'b1);
    check("tmo_rdata",       ls_rdata, 32'h0);
    check("model_tmo_err",   e.err,    1'b1);
    ls_req = 1'b0;
    tick();
    check("tmo_err_pulse", err, 1'b0);

    // Reset in the second BUSY cycle, then the held fetch is served afresh.
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b0; mem_rdata = 32'h12345678;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rstb_mem_en",   mem_en,   1'b0);
    check("rstb_mem_addr", mem_addr, 32'h0);
    check("rstb_mem_be",   mem_be,   4'h0);
    check("rstb_if_ack",   if_ack,   1'b0);
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("rstb_refetch_ack",   got,      1'b1);
    check("rstb_refetch_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Stray mem_ready with nobody requesting.
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stray_if_ack", if_ack, 1'b0);
      check("stray_ls_ack", ls_ack, 1'b0);
      check("stray_mem_en", mem_en, 1'b0);
    end
    mem_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
